// File: rtl/dsp_pkg.sv
// Shared types and constants for the voice mixer: FSM states, sample/volume widths
// and the 16-bit saturation helper.
package dsp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    SCALE = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int SAMPLE_W  = 16;
  localparam int VOL_W     = 8;
  localparam int VOL_SHIFT = 7;

  function automatic logic signed [15:0] clamp16(input logic signed [31:0] x);
    if (x > 32'sd32767)
      return 16'sh7FFF;
    else if (x < -32'sd32768)
      return 16'sh8000;
    return x[15:0];
  endfunction

endpackage

// File: rtl/dsp_mac_lane.sv
// One mixer channel: per-voice multiply/shift/accumulate, then master-volume scale
// into the registered DAC word. Saturating when DSP_MIX_CLAMP_EN is defined, wrapping otherwise.
module dsp_mac_lane
  import dsp_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int COEF_W = VOL_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mac_en,
  input  logic                     acc_clear,
  input  logic                     voice_on,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] vol,
  input  logic                     scale_en,
  input  logic                     mute,
  input  logic signed [COEF_W-1:0] mvol,
  output logic signed [DATA_W-1:0] mix_p1
);

  localparam int PROD_W = DATA_W + COEF_W;

  function automatic logic signed [DATA_W-1:0] reduce(input logic signed [31:0] x);
`ifdef DSP_MIX_CLAMP_EN
    return clamp16(x);
`else
    return x[DATA_W-1:0];
`endif
  endfunction

  logic signed [DATA_W-1:0] acc_p0;
  logic signed [DATA_W-1:0] acc_prior;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] prod_sh;
  logic signed [31:0]       sum;
  logic signed [PROD_W-1:0] mprod;
  logic signed [31:0]       mscaled;

  // Stage 0: voice product, floor shift and accumulate (first voice starts from zero)
  assign acc_prior = acc_clear ? '0 : acc_p0;
  assign prod      = PROD_W'(sample) * PROD_W'(vol);
  assign prod_sh   = prod >>> VOL_SHIFT;
  assign sum       = 32'(acc_prior) + (voice_on ? 32'(prod_sh) : 32'sd0);

  // Stage 1: master volume applied to the finished accumulation
  assign mprod   = PROD_W'(acc_p0) * PROD_W'(mvol);
  assign mscaled = 32'(mprod >>> VOL_SHIFT);

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_p0 <= '0;
      mix_p1 <= '0;
    end else begin
      if (mac_en)
        acc_p0 <= reduce(sum);
      if (scale_en)
        mix_p1 <= mute ? '0 : reduce(mscaled);
    end
  end

endmodule

// File: rtl/dsp_voice_mixer.sv
// Time-multiplexed stereo voice mixer: one voice per clock into L/R accumulators, then
// master scale and DAC update once per frame. Optional saturation via DSP_MIX_CLAMP_EN.
module dsp_voice_mixer
  import dsp_pkg::*;
#(
  parameter int N_VOICES          = 8,
  parameter int CLOCKS_PER_SAMPLE = 64
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N_VOICES*SAMPLE_W-1:0]        voice_sample,
  input  logic [N_VOICES*VOL_W-1:0]           vol_l,
  input  logic [N_VOICES*VOL_W-1:0]           vol_r,
  input  logic signed [VOL_W-1:0]             mvol_l,
  input  logic signed [VOL_W-1:0]             mvol_r,
  input  logic [N_VOICES-1:0]                 voice_en,
  input  logic                                mute,
  output logic signed [SAMPLE_W-1:0]          dac_out_l,
  output logic signed [SAMPLE_W-1:0]          dac_out_r,
  output logic                                dac_valid,
  output logic [$clog2(CLOCKS_PER_SAMPLE)-1:0] step
);

  localparam int STEP_W = $clog2(CLOCKS_PER_SAMPLE);
  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(CLOCKS_PER_SAMPLE - 1);
  localparam logic [STEP_W-1:0] LAST_VOICE = STEP_W'(N_VOICES - 1);

  if (CLOCKS_PER_SAMPLE < N_VOICES + 2) begin : g_bad_cps
    $error("dsp_voice_mixer: CLOCKS_PER_SAMPLE must be at least N_VOICES+2");
  end
  if (N_VOICES < 1 || N_VOICES > 16) begin : g_bad_nv
    $error("dsp_voice_mixer: N_VOICES must be in 1..16");
  end

  state_t state, state_next;
  logic   frame_start;

  logic signed [SAMPLE_W-1:0] cur_sample;
  logic signed [VOL_W-1:0]    cur_vol_l;
  logic signed [VOL_W-1:0]    cur_vol_r;
  logic                       cur_en;
  logic                       mac_en;
  logic                       acc_clear;
  logic                       scale_en;

  // Reset parks the counter on the last step so the frame starts on the first free edge
  always_ff @(posedge clock) begin
    if (reset)
      step <= LAST_STEP;
    else if (step == LAST_STEP)
      step <= '0;
    else
      step <= step + 1'b1;
  end

  assign frame_start = (step == LAST_STEP);

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = MAC;
      MAC:     if (step == LAST_VOICE) state_next = SCALE;
      SCALE:   state_next = OUT;
      OUT:     state_next = frame_start ? MAC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Live selection of the voice addressed by the current step
  always_comb begin
    cur_sample = '0;
    cur_vol_l  = '0;
    cur_vol_r  = '0;
    cur_en     = 1'b0;
    for (int k = 0; k < N_VOICES; k++) begin
      if (step == STEP_W'(k)) begin
        cur_sample = voice_sample[SAMPLE_W*k +: SAMPLE_W];
        cur_vol_l  = vol_l[VOL_W*k +: VOL_W];
        cur_vol_r  = vol_r[VOL_W*k +: VOL_W];
        cur_en     = voice_en[k];
      end
    end
  end

  assign mac_en    = (state == MAC);
  assign acc_clear = mac_en && (step == '0);
  assign scale_en  = (state == SCALE);
  assign dac_valid = (state == OUT);

  dsp_mac_lane #(.DATA_W(SAMPLE_W), .COEF_W(VOL_W)) u_lane_l (
    .clock     (clock),
    .reset     (reset),
    .mac_en    (mac_en),
    .acc_clear (acc_clear),
    .voice_on  (cur_en),
    .sample    (cur_sample),
    .vol       (cur_vol_l),
    .scale_en  (scale_en),
    .mute      (mute),
    .mvol      (mvol_l),
    .mix_p1    (dac_out_l)
  );

  dsp_mac_lane #(.DATA_W(SAMPLE_W), .COEF_W(VOL_W)) u_lane_r (
    .clock     (clock),
    .reset     (reset),
    .mac_en    (mac_en),
    .acc_clear (acc_clear),
    .voice_on  (cur_en),
    .sample    (cur_sample),
    .vol       (cur_vol_r),
    .scale_en  (scale_en),
    .mute      (mute),
    .mvol      (mvol_r),
    .mix_p1    (dac_out_r)
  );

endmodule

// File: tb/tb_dsp_voice_mixer.sv
// Directed bench for dsp_voice_mixer: hand-computed frames for gain, polarity, overflow,
// mute, voice enable, live sampling and mid-frame reset.
module tb_dsp_voice_mixer;

  localparam int N   = 8;
  localparam int CPS = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic [N*16-1:0]   voice_sample;
  logic [N*8-1:0]    vol_l;
  logic [N*8-1:0]    vol_r;
  logic signed [7:0] mvol_l;
  logic signed [7:0] mvol_r;
  logic [N-1:0]      voice_en;
  logic              mute;
  logic signed [15:0] dac_out_l;
  logic signed [15:0] dac_out_r;
  logic              dac_valid;
  logic [3:0]        step;

  int passed = 0;
  int total  = 0;

  dsp_voice_mixer #(.N_VOICES(N), .CLOCKS_PER_SAMPLE(CPS)) dut (
    .clock        (clock),
    .reset        (reset),
    .voice_sample (voice_sample),
    .vol_l        (vol_l),
    .vol_r        (vol_r),
    .mvol_l       (mvol_l),
    .mvol_r       (mvol_r),
    .voice_en     (voice_en),
    .mute         (mute),
    .dac_out_l    (dac_out_l),
    .dac_out_r    (dac_out_r),
    .dac_valid    (dac_valid),
    .step         (step)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_step(input int s);
    int n = 0;
    @(negedge clock);
    while (32'(step) != s && n < 4*CPS) begin
      @(negedge clock);
      n++;
    end
    check("step_reach", 32'(step), s);
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clock);
    while (dac_valid !== 1'b1 && n < 4*CPS) begin
      @(negedge clock);
      n++;
    end
    check("valid_seen", 32'(dac_valid), 1);
    check("valid_step", 32'(step), N + 1);
  endtask

  task automatic clear_inputs();
    voice_sample = '0;
    vol_l        = '0;
    vol_r        = '0;
    mvol_l       = 8'sh7F;
    mvol_r       = 8'sh7F;
    voice_en     = '1;
    mute         = 1'b0;
  endtask

  task automatic set_voice(input int k, input logic [15:0] s, input logic [7:0] vl, input logic [7:0] vr);
    voice_sample[16*k +: 16] = s;
    vol_l[8*k +: 8]          = vl;
    vol_r[8*k +: 8]          = vr;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clock);
    check("rst_step", 32'(step), CPS - 1);
    check("rst_l", dac_out_l, 0);
    check("rst_r", dac_out_r, 0);
    check("rst_valid", 32'(dac_valid), 0);
    reset = 1'b0;
    @(negedge clock);
    check("first_step", 32'(step), 0);

    // Single voice, positive gains
    wait_step(CPS - 1);
    clear_inputs();
    set_voice(0, 16'h4000, 8'h7F, 8'h00);
    voice_en = 8'h01;
    wait_valid();
    check("gain_l", dac_out_l, 16129);
    check("gain_r", dac_out_r, 0);
    @(negedge clock);
    check("valid_drop", 32'(dac_valid), 0);
    check("hold_l", dac_out_l, 16129);

    // Negative right volume, left unaffected
    wait_step(CPS - 1);
    set_voice(0, 16'h4000, 8'h7F, 8'h80);
    wait_valid();
    check("neg_l", dac_out_l, 16129);
    check("neg_r", dac_out_r, -16256);

    // Full-scale on all voices: saturation or wrap
    wait_step(CPS - 1);
    clear_inputs();
    for (int k = 0; k < N; k++) set_voice(k, 16'h7FFF, 8'h7F, 8'h7F);
    wait_valid();
`ifdef DSP_MIX_CLAMP_EN
    check("ovf_l", dac_out_l, 32511);
    check("ovf_r", dac_out_r, 32511);
`else
    check("ovf_l", dac_out_l, -2040);
    check("ovf_r", dac_out_r, -2040);
`endif

    // Mixed signs with floor on the negative product
    wait_step(CPS - 1);
    clear_inputs();
    set_voice(0, 16'd1000, 8'h40, 8'h00);
    set_voice(2, 16'hFED4, 8'h64, 8'h00);
    voice_en = 8'h05;
    mvol_l   = 8'sh40;
    wait_valid();
    check("mix_l", dac_out_l, 132);
    check("mix_r", dac_out_r, 0);

    // Mute for one frame, then restore
    wait_step(CPS - 1);
    clear_inputs();
    set_voice(0, 16'h4000, 8'h7F, 8'h80);
    voice_en = 8'h01;
    mute     = 1'b1;
    wait_valid();
    check("mute_l", dac_out_l, 0);
    check("mute_r", dac_out_r, 0);
    wait_step(CPS - 1);
    mute = 1'b0;
    wait_valid();
    check("unmute_l", dac_out_l, 16129);
    check("unmute_r", dac_out_r, -16256);

    // Voice 0 disabled, only the silent voice 1 enabled
    wait_step(CPS - 1);
    voice_en = 8'b0000_0010;
    set_voice(1, 16'h0000, 8'h7F, 8'h7F);
    wait_valid();
    check("en_l", dac_out_l, 0);
    check("en_r", dac_out_r, 0);

    // Voice 0 changes after its own step must not matter
    wait_step(CPS - 1);
    clear_inputs();
    set_voice(0, 16'h4000, 8'h7F, 8'h00);
    voice_en = 8'h01;
    wait_step(1);
    set_voice(0, 16'h7FFF, 8'h01, 8'h7F);
    wait_valid();
    check("live_l", dac_out_l, 16129);
    check("live_r", dac_out_r, 0);

    // Reset mid-frame at step 4
    wait_step(CPS - 1);
    set_voice(0, 16'h4000, 8'h7F, 8'h80);
    wait_step(4);
    reset = 1'b1;
    @(negedge clock);
    check("mrst_l", dac_out_l, 0);
    check("mrst_r", dac_out_r, 0);
    check("mrst_step", 32'(step), CPS - 1);
    reset = 1'b0;
    wait_step(N);
    check("post_rst_l", dac_out_l, 0);
    check("post_rst_valid", 32'(dac_valid), 0);
    wait_valid();
    check("rst_frame_l", dac_out_l, 16129);
    check("rst_frame_r", dac_out_r, -16256);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
